// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus FSM/counter debouncer for one active-low push-button.
// Defining KEY_REPEAT_EN adds auto-repeat strobes while the key stays held.
module key_debounce #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_n,
    output logic       key_flag,
    output logic       key_release,
    output logic       key_level,
    output logic [3:0] press_count
);

    localparam int unsigned DB_CNT   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned LONG_CNT = CLK_FREQ_HZ / 1000 * LONG_MS;
    localparam int unsigned REP_CNT  = CLK_FREQ_HZ / 1000 * REPEAT_MS;

`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    // Counter width only has to cover the hold/repeat counts when auto-repeat is built in.
    localparam int unsigned RPT_MAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
    localparam int unsigned MAX_CNT = (REPEAT_ON && (RPT_MAX > DB_CNT)) ? RPT_MAX : DB_CNT;
    localparam int unsigned CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    logic          sync1;
    logic          key_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          press_ok;
    logic          rpt_fire;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            key_s <= 1'b1;
        end else begin
            sync1 <= key_n;
            key_s <= sync1;
        end
    end

    assign press_ok = (state == PRESS_DB) && !key_s && (cnt == DB_LAST);

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] RELOAD    = CW'(LONG_CNT - REP_CNT);

    logic [CW-1:0] hold_cnt;

    assign rpt_fire = (state == HELD) && !key_s && (hold_cnt == LONG_LAST);

    // Reload after each repeat so the next one lands REP_CNT cycles later; frozen outside HELD.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_cnt <= '0;
        end else if (press_ok) begin
            hold_cnt <= '0;
        end else if ((state == HELD) && !key_s) begin
            hold_cnt <= rpt_fire ? RELOAD : hold_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_level   <= 1'b0;
            press_count <= '0;
        end else begin
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (key_s) begin
                        state <= IDLE;
                    end else if (press_ok) begin
                        state       <= HELD;
                        key_flag    <= 1'b1;
                        key_level   <= 1'b1;
                        press_count <= press_count + 4'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end else if (rpt_fire) begin
                        key_flag    <= 1'b1;
                        press_count <= press_count + 4'd1;
                    end
                end
                RELEASE_DB: begin
                    if (!key_s) begin
                        state <= HELD;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, directed corner sequences and random bounce
// patterns checked every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_n     = 1'b1;
    logic       key_flag;
    logic       key_release;
    logic       key_level;
    logic [3:0] press_count;

    int checks = 0;
    int errors = 0;
    int n_flag = 0;
    int n_rel  = 0;

    key_debounce #(
        .CLK_FREQ_HZ(1000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20),
        .REPEAT_MS  (5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_n      (key_n),
        .key_flag   (key_flag),
        .key_release(key_release),
        .key_level  (key_level),
        .press_count(press_count)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (key_flag)    n_flag++;
        if (key_release) n_rel++;
    end

    // Reference model: a press is valid once the synchronised input has been low for
    // DB+1 consecutive samples (release symmetric); repeats count undisturbed held cycles.
    bit hist[$] = '{1'b1, 1'b1};
    bit m_level = 1'b0;
    bit m_flag  = 1'b0;
    bit m_rel   = 1'b0;
    bit last_in = 1'b1;
    int m_count = 0;
    int run_len = 0;
    int held    = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin : model
        bit smp;
        if (!sys_rst_n) begin
            hist    = '{1'b1, 1'b1};
            m_level = 1'b0;
            m_flag  = 1'b0;
            m_rel   = 1'b0;
            last_in = 1'b1;
            m_count = 0;
            run_len = 0;
            held    = 0;
        end else begin
            hist.push_back(key_n);
            smp    = hist.pop_front();
            m_flag = 1'b0;
            m_rel  = 1'b0;
            run_len = (smp == last_in) ? run_len + 1 : 1;
            if (!m_level) begin
                if (!smp && run_len == DB + 1) begin
                    m_flag  = 1'b1;
                    m_level = 1'b1;
                    m_count = (m_count + 1) % 16;
                    held    = 0;
                end
            end else if (smp && run_len == DB + 1) begin
                m_rel   = 1'b1;
                m_level = 1'b0;
            end else if (REP_EN && !smp && !last_in) begin
                held++;
                if (held >= LONG && (held - LONG) % REP == 0) begin
                    m_flag  = 1'b1;
                    m_count = (m_count + 1) % 16;
                end
            end
            last_in = smp;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic scoreboard();
        forever begin
            @(negedge sys_clk);
            check("sb_flag", key_flag, m_flag);
            check("sb_release", key_release, m_rel);
            check("sb_level", key_level, m_level);
            check("sb_count", press_count, m_count);
            check("sb_exclusive", key_flag & key_release, 0);
        end
    endtask

    // Drive key_n at a negedge and hold it for n clock samples.
    task automatic seg(input logic val, input int n);
        key_n = val;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    typedef struct {
        string name;
        int    low1;
        int    high1;
        int    low2;
        int    high2;
        int    flags;
        int    rels;
        int    delta;
    } vec_t;

    vec_t vecs[8];
    int   exp_cnt;
    int   base_f;
    int   base_r;
    bit   found;
    int   len;

    initial begin
        vecs[0] = '{"clean",       12, 12, 0,  0, 1, 1, 1};
        vecs[1] = '{"glitch3",      3, 12, 0,  0, 0, 0, 0};
        vecs[2] = '{"glitch4",      4, 12, 0,  0, 0, 0, 0};
        vecs[3] = '{"min_press",    5, 12, 0,  0, 1, 1, 1};
        vecs[4] = '{"bounce",       3,  2, 3, 12, 0, 0, 0};
        vecs[5] = '{"rel_bounce2", 12,  2, 8, 12, 1, 1, 1};
        vecs[6] = '{"rel_bounce1", 12,  1, 8, 12, 1, 1, 1};
        vecs[7] = '{"min_release", 12,  5, 12, 12, 2, 2, 2};

        fork
            scoreboard();
        join_none

        repeat (3) @(negedge sys_clk);
        check("reset_flag", key_flag, 0);
        check("reset_release", key_release, 0);
        check("reset_level", key_level, 0);
        check("reset_count", press_count, 0);
        sys_rst_n = 1'b1;
        seg(1'b1, 5);
        exp_cnt = 0;

        foreach (vecs[v]) begin
            base_f = n_flag;
            base_r = n_rel;
            seg(1'b0, vecs[v].low1);
            seg(1'b1, vecs[v].high1);
            seg(1'b0, vecs[v].low2);
            seg(1'b1, vecs[v].high2);
            exp_cnt = (exp_cnt + vecs[v].delta) % 16;
            check({vecs[v].name, "_flags"}, n_flag - base_f, vecs[v].flags);
            check({vecs[v].name, "_rels"}, n_rel - base_r, vecs[v].rels);
            check({vecs[v].name, "_count"}, press_count, exp_cnt);
            check({vecs[v].name, "_level"}, key_level, 0);
        end

        // Exact press/release latency: strobe after the 7th edge counting E0 as edge 0.
        key_n = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk);
            #1 check("lat_press", key_flag, (i == 6));
        end
        check("lat_level_hi", key_level, 1);
        @(negedge sys_clk);
        key_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk);
            #1 check("lat_release", key_release, (i == 6));
        end
        check("lat_level_lo", key_level, 0);
        @(negedge sys_clk);
        seg(1'b1, 5);

        // 16 presses from reset wrap the counter back to zero.
        do_reset();
        base_f = n_flag;
        for (int i = 1; i <= 16; i++) begin
            seg(1'b0, 12);
            seg(1'b1, 12);
            check("wrap_count", press_count, i % 16);
        end
        check("wrap_flags", n_flag - base_f, 16);

        // Reset while held, key still down afterwards: one fresh press, no release.
        seg(1'b0, 15);
        check("pre_rst_level", key_level, 1);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_imm_level", key_level, 0);
        check("rst_imm_count", press_count, 0);
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        base_r = n_rel;
        for (int i = 0; i < 9; i++) begin
            @(posedge sys_clk);
            #1 check("rst_flag", key_flag, (i == 6));
        end
        @(negedge sys_clk);
        seg(1'b0, 3);
        check("rst_no_release", n_rel - base_r, 0);
        check("rst_count", press_count, 1);
        seg(1'b1, 12);
        check("rst_real_release", n_rel - base_r, 1);

        // Long hold: repeats at +20,+25,...,+40 after the press strobe when enabled.
        do_reset();
        key_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            if (key_flag) begin
                found = 1'b1;
                break;
            end
        end
        check("hold_press_seen", found, 1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge sys_clk);
            #1 check("hold_strobe", key_flag, REP_EN && k >= LONG && (k - LONG) % REP == 0);
        end
        check("hold_count", press_count, REP_EN ? 6 : 1);
        @(negedge sys_clk);
        seg(1'b1, 12);
        check("hold_level", key_level, 0);

        // Random bounce patterns, checked cycle by cycle by the scoreboard.
        for (int s = 0; s < 120; s++) begin
            len = (s % 12 == 11) ? $urandom_range(20, 45) : $urandom_range(1, 8);
            seg(s[0], len);
        end
        seg(1'b1, 15);
        check("rand_level", key_level, m_level);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
